sdram_wb_bridge: RTL

//  Bridge from the kernel's 16-bit Wishbone SDRAM port (stb/we/sel/adr/out/dat/ack) to the sdram_top
//  req/ack controller. Owns the controller reset-release sequencing, per-transaction latching of

---
 rtl/sdram_wb_bridge_pkg.sv | 16 +
 rtl/sdram_wb_bridge_rst_seq.sv | 32 +++
 rtl/sdram_wb_bridge.sv | 122 ++++++++++++
 3 files changed

// File: rtl/sdram_wb_bridge_pkg.sv
// Shared definitions for the Wishbone-to-SDRAM-controller bridge:
// FSM encodings, controller address widths and the read byte mask.
package sdram_wb_bridge_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_ACK  = 2'd2
   } state_t;

   localparam int         CTL_AW  = 23;
   localparam int         ADR_W   = 21;
   localparam int         PAD_W   = CTL_AW - ADR_W;
   localparam logic [1:0] DM_READ = 2'b00;

endpackage

// File: rtl/sdram_wb_bridge_rst_seq.sv
// Controller reset-release sequencer: synchronises reset deassertion, then
// holds ctl_rst_n low for RST_DELAY more cycles before releasing it.
module sdram_wb_bridge_rst_seq #(
   parameter int RST_DELAY = 3
) (
   input  logic clk,
   input  logic rst,
   output logic ctl_rst_n
);

   localparam int CW = (RST_DELAY < 2) ? 1 : $clog2(RST_DELAY + 1);

   logic [1:0]    sync;
   logic [CW-1:0] cnt;

   // Down-counter runs only after the synchroniser has flushed; release is
   // registered on the final decrement so ctl_rst_n is glitch-free.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync      <= 2'b11;
         cnt       <= CW'(RST_DELAY);
         ctl_rst_n <= 1'b0;
      end else begin
         sync <= {sync[0], 1'b0};
         if (!sync[1]) begin
            if (cnt != '0) cnt <= cnt - 1'b1;
            if (cnt <= CW'(1)) ctl_rst_n <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/sdram_wb_bridge.sv
// Bridge from a 16-bit Wishbone port to the sdram_top req/ack controller,
// with reset sequencing, per-transaction latching and an ack watchdog.
//
// state    | meaning
// ST_IDLE  | waiting for wb_stb_i while ready_o
// ST_REQ   | request level held to controller, watchdog running
// ST_ACK   | wb_ack_o shown while wb_stb_i stays high
module sdram_wb_bridge
   import sdram_wb_bridge_pkg::*;
#(
   parameter int RST_DELAY = 3,
   parameter int TIMEOUT   = 1023,
   parameter int TO_W      = 10
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              wb_stb_i,
   input  logic              wb_we_i,
   input  logic [1:0]        wb_sel_i,
   input  logic [ADR_W-1:0]  wb_adr_i,
   input  logic [15:0]       wb_dat_i,
   output logic [15:0]       wb_dat_o,
   output logic              wb_ack_o,
   output logic              ready_o,
   output logic              timeout_o,
   output logic              ctl_rst_n,
   input  logic              ctl_init_done,
   output logic              ctl_wr_req,
   output logic              ctl_rd_req,
   input  logic              ctl_wr_ack,
   input  logic              ctl_rd_ack,
   output logic [CTL_AW-1:0] ctl_addr,
   output logic [15:0]       ctl_wdata,
   input  logic [15:0]       ctl_rdata,
   output logic [1:0]        ctl_dm
);

   state_t           state, state_nxt;
   logic [ADR_W-1:0] adr_l;
   logic             we_l;
   logic [TO_W-1:0]  wd_cnt;
   logic             init_q;
   logic             ack_hit;
   logic             wd_exp;
   logic             accept;

   sdram_wb_bridge_rst_seq #(.RST_DELAY(RST_DELAY)) u_rst_seq (
      .clk       (wb_clk_i),
      .rst       (wb_rst_i),
      .ctl_rst_n (ctl_rst_n)
   );

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) init_q <= 1'b0;
      else          init_q <= ctl_init_done;
   end

   assign ready_o  = ctl_rst_n & init_q;
   // Only the ack matching the latched direction completes the transaction.
   assign ack_hit  = we_l ? ctl_wr_ack : ctl_rd_ack;
   assign wd_exp   = (wd_cnt == '0);
   assign accept   = wb_stb_i & ready_o;
   assign ctl_addr = {{PAD_W{1'b0}}, adr_l};

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      ctl_wr_req = 1'b0;
      ctl_rd_req = 1'b0;
      wb_ack_o   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept) state_nxt = ST_REQ;
         end
         ST_REQ: begin
            ctl_wr_req = we_l;
            ctl_rd_req = ~we_l;
            if (ack_hit || wd_exp) state_nxt = ST_ACK;
         end
         ST_ACK: begin
            wb_ack_o = wb_stb_i;
            if (!wb_stb_i) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         adr_l     <= '0;
         we_l      <= 1'b0;
         ctl_wdata <= '0;
         ctl_dm    <= 2'b00;
         wd_cnt    <= '0;
         wb_dat_o  <= '0;
         timeout_o <= 1'b0;
      end else begin
         if (state == ST_IDLE && accept) begin
            adr_l     <= wb_adr_i;
            we_l      <= wb_we_i;
            ctl_wdata <= wb_dat_i;
            ctl_dm    <= wb_we_i ? ~wb_sel_i : DM_READ;
            wd_cnt    <= TO_W'(TIMEOUT - 1);
         end
         if (state == ST_REQ) begin
            if (ack_hit) begin
               if (!we_l) wb_dat_o <= ctl_rdata;
            end else if (wd_exp) begin
               if (!we_l) wb_dat_o <= 16'hFFFF;
               timeout_o <= 1'b1;
            end else begin
               wd_cnt <= wd_cnt - 1'b1;
            end
         end
      end
   end

endmodule
